// File: rtl/led_matrix_pkg.sv
// Shared LED-matrix types and constants, used by the frame buffer and the row scanner.
package led_matrix_pkg;

  localparam int LED_ROWS = 8;
  localparam int LED_COLS = 8;

  typedef logic [2:0]          row_idx_t;
  typedef logic [LED_COLS-1:0] row_bits_t;

  typedef enum logic {
    SWP_IDLE,
    SWP_PENDING
  } swap_state_t;

  // Blank a row bitmap when the blink mask is active.
  function automatic row_bits_t apply_blink(row_bits_t bits, logic blank);
    return blank ? '0 : bits;
  endfunction

endpackage

// File: rtl/led_blink_div.sv
// Free-running blink divider; raw_phase flips every time the divider wraps to zero.
module led_blink_div #(
  parameter int BLINK_DIV_W = 25
) (
  input  logic clk,
  input  logic rst,
  output logic raw_phase
);

  localparam logic [BLINK_DIV_W-1:0] DIV_ONE = BLINK_DIV_W'(1);

  logic [BLINK_DIV_W-1:0] div_cnt;

  // Divider counts every clock; overflow back to zero is the intended wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      raw_phase <= 1'b0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
      if (&div_cnt) begin
        raw_phase <= ~raw_phase;
      end
    end
  end

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered 8x8 bitmap feeding the LED row scanner.
// Swaps and blink phase changes only take effect at scan frame boundaries.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   SWP_IDLE    | no swap requested; back bank accepts writes
//   SWP_PENDING | swap requested; waiting for scan_frame_end, writes dropped
module led_frame_buffer
  import led_matrix_pkg::*;
#(
  parameter int BLINK_DIV_W = 25
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  row_idx_t  wr_row,
  input  row_bits_t wr_data,
  output logic      wr_ready,
  input  logic      swap_req,
  output logic      busy,
  output logic      swap_ack,
  input  row_idx_t  scan_row,
  input  logic      scan_frame_end,
  input  logic      blink_en,
  output row_bits_t row_data
);

  swap_state_t state_q, state_d;
  logic        swap_fire;
  logic        front_sel;
  logic        back_sel;
  logic        raw_phase;
  logic        eff_phase;
  row_bits_t   bank [2][LED_ROWS];

  assign busy     = (state_q == SWP_PENDING);
  assign wr_ready = ~busy;
  assign back_sel = ~front_sel;

  led_blink_div #(
    .BLINK_DIV_W(BLINK_DIV_W)
  ) u_blink_div (
    .clk       (clk),
    .rst       (rst),
    .raw_phase (raw_phase)
  );

  // Swap FSM next state; a request arriving with frame_end still waits a full frame.
  always_comb begin
    state_d   = state_q;
    swap_fire = 1'b0;
    case (state_q)
      SWP_IDLE: begin
        if (swap_req) begin
          state_d = SWP_PENDING;
        end
      end
      SWP_PENDING: begin
        if (scan_frame_end) begin
          state_d   = SWP_IDLE;
          swap_fire = 1'b1;
        end
      end
      default: state_d = SWP_IDLE;
    endcase
  end

  // Swap FSM state, displayed-bank select and the acknowledge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SWP_IDLE;
      front_sel <= 1'b0;
      swap_ack  <= 1'b0;
    end else begin
      state_q  <= state_d;
      swap_ack <= swap_fire;
      if (swap_fire) begin
        front_sel <= ~front_sel;
      end
    end
  end

  // Back-bank writes, refused while a swap is pending so the new frame stays intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < LED_ROWS; r++) begin
          bank[b][r] <= '0;
        end
      end
    end else if (wr_en && !busy) begin
      bank[back_sel][wr_row] <= wr_data;
    end
  end

  // Blink phase latched only at frame end so a frame is never partly blanked.
  always_ff @(posedge clk) begin
    if (rst) begin
      eff_phase <= 1'b0;
    end else if (scan_frame_end) begin
      eff_phase <= raw_phase;
    end
  end

  // Registered front-bank read; the swap-edge read still sees the old front.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_data <= '0;
    end else begin
      row_data <= apply_blink(bank[front_sel][scan_row], blink_en && eff_phase);
    end
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Self-checking bench for led_frame_buffer with a short blink divider.
module tb_led_frame_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       swap_req;
  logic       busy;
  logic       swap_ack;
  logic [2:0] scan_row;
  logic       scan_frame_end;
  logic       blink_en;
  logic [7:0] row_data;

  int checks   = 0;
  int failures = 0;
  int ack_seen = 0;

  // Reference model: two whole frames exchanged on swap, blink phase from elapsed cycles.
  logic [7:0] m_front [8];
  logic [7:0] m_back  [8];
  logic       m_busy;
  logic       m_ack;
  logic       m_eff;
  logic [7:0] m_row;
  int         m_cnt;

  typedef struct {
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       fe;
    logic [2:0] scan;
    logic       e_busy;
    logic       e_ack;
    logic [7:0] e_row;
  } vec_t;

  vec_t tbl [20];
  logic [7:0] pattern [8];

  led_frame_buffer #(.BLINK_DIV_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_row         (wr_row),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .swap_req       (swap_req),
    .busy           (busy),
    .swap_ack       (swap_ack),
    .scan_row       (scan_row),
    .scan_frame_end (scan_frame_end),
    .blink_en       (blink_en),
    .row_data       (row_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic we, logic [2:0] wrow, logic [7:0] wd, logic sr, logic fe,
                               logic [2:0] sc, logic eb, logic ea, logic [7:0] er);
    vec_t v;
    v.wr_en = we; v.wr_row = wrow; v.wr_data = wd; v.swap_req = sr; v.fe = fe;
    v.scan = sc; v.e_busy = eb; v.e_ack = ea; v.e_row = er;
    return v;
  endfunction

  // One clock: update the model from the current inputs, clock the DUT, compare.
  task automatic step();
    logic [7:0] tmp;
    if (rst) begin
      for (int r = 0; r < 8; r++) begin
        m_front[r] = 8'h00;
        m_back[r]  = 8'h00;
      end
      m_busy = 1'b0;
      m_ack  = 1'b0;
      m_eff  = 1'b0;
      m_cnt  = 0;
      m_row  = 8'h00;
    end else begin
      m_row = (blink_en && m_eff) ? 8'h00 : m_front[scan_row];
      if (wr_en && !m_busy) m_back[wr_row] = wr_data;
      m_ack = 1'b0;
      if (m_busy) begin
        if (scan_frame_end) begin
          for (int r = 0; r < 8; r++) begin
            tmp        = m_front[r];
            m_front[r] = m_back[r];
            m_back[r]  = tmp;
          end
          m_busy = 1'b0;
          m_ack  = 1'b1;
        end
      end else if (swap_req) begin
        m_busy = 1'b1;
      end
      if (scan_frame_end) m_eff = ((m_cnt / 16) % 2) == 1;
      m_cnt++;
    end
    @(posedge clk);
    #1;
    check("row_data", row_data, m_row);
    check("busy", {7'b0, busy}, {7'b0, m_busy});
    check("swap_ack", {7'b0, swap_ack}, {7'b0, m_ack});
    check("wr_ready", {7'b0, wr_ready}, {7'b0, !m_busy});
    if (swap_ack) ack_seen++;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_row = 0; wr_data = 0; swap_req = 0; scan_frame_end = 0;
  endtask

  initial begin
    pattern[0] = 8'h18; pattern[1] = 8'h3C; pattern[2] = 8'h7E; pattern[3] = 8'hFF;
    pattern[4] = 8'hFF; pattern[5] = 8'h7E; pattern[6] = 8'h3C; pattern[7] = 8'h18;
    for (int i = 0; i < 8; i++)
      tbl[i] = mkv(1, 3'(i), pattern[i], 0, 0, 0, 0, 0, 8'h00);
    tbl[8]  = mkv(0, 0, 0, 1, 0, 0, 1, 0, 8'h00);
    tbl[9]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    tbl[10] = mkv(0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    tbl[11] = mkv(0, 0, 0, 0, 1, 3, 0, 1, 8'h00);
    for (int i = 0; i < 8; i++)
      tbl[12+i] = mkv(0, 0, 0, 0, 0, 3'(i), 0, 0, pattern[i]);

    idle_inputs();
    scan_row = 0;
    blink_en = 0;
    rst = 1;
    step();
    step();
    rst = 0;

    // Reset state: every row reads back zero.
    for (int r = 0; r < 8; r++) begin
      scan_row = 3'(r);
      step();
      check("reset_row", row_data, 8'h00);
    end

    // Fill back bank, request swap, frame end three cycles later.
    for (int i = 0; i < 20; i++) begin
      wr_en = tbl[i].wr_en; wr_row = tbl[i].wr_row; wr_data = tbl[i].wr_data;
      swap_req = tbl[i].swap_req; scan_frame_end = tbl[i].fe; scan_row = tbl[i].scan;
      step();
      check("tbl_busy", {7'b0, busy}, {7'b0, tbl[i].e_busy});
      check("tbl_ack", {7'b0, swap_ack}, {7'b0, tbl[i].e_ack});
      check("tbl_row", row_data, tbl[i].e_row);
    end
    idle_inputs();

    // Request coinciding with frame end waits; a second request while busy is ignored.
    ack_seen = 0;
    swap_req = 1; scan_frame_end = 1;
    step();
    check("same_cycle_no_swap", {7'b0, busy}, 8'h01);
    swap_req = 0; scan_frame_end = 0;
    step();
    swap_req = 1;
    step();
    swap_req = 0;
    step();
    scan_frame_end = 1;
    step();
    scan_frame_end = 0;
    for (int i = 0; i < 4; i++) step();
    check("single_ack", 8'(ack_seen), 8'h01);

    // Write while busy is dropped; write after busy drops shows only after the next swap.
    swap_req = 1;
    step();
    swap_req = 0;
    wr_en = 1; wr_row = 2; wr_data = 8'hAA;
    step();
    wr_en = 0;
    scan_frame_end = 1;
    step();
    scan_frame_end = 0;
    scan_row = 2;
    step();
    check("dropped_write", row_data, 8'h7E);
    wr_en = 1; wr_row = 2; wr_data = 8'hAA;
    step();
    wr_en = 0;
    step();
    check("no_show_before_swap", row_data, 8'h7E);
    swap_req = 1;
    step();
    swap_req = 0;
    scan_frame_end = 1;
    step();
    scan_frame_end = 0;
    step();
    check("show_after_swap", row_data, 8'hAA);
    swap_req = 1;
    step();
    swap_req = 0;
    scan_frame_end = 1;
    step();
    scan_frame_end = 0;

    // Blink with a scanner-like row sweep and frame end on every 7->0 wrap.
    blink_en = 1;
    for (int c = 0; c < 96; c++) begin
      scan_row = 3'(c % 8);
      scan_frame_end = (c % 8) == 7;
      step();
    end
    for (int c = 0; c < 48 && !m_eff; c++) begin
      scan_row = 3'(c % 8);
      scan_frame_end = (c % 8) == 7;
      step();
    end
    scan_frame_end = 0;
    scan_row = 3;
    step();
    check("blink_blanked", row_data, 8'h00);
    blink_en = 0;
    step();
    check("blink_cleared", row_data, 8'hFF);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      wr_en          = $urandom_range(0, 1);
      wr_row         = 3'($urandom_range(0, 7));
      wr_data        = 8'($urandom);
      swap_req       = ($urandom_range(0, 7) == 0);
      scan_frame_end = ($urandom_range(0, 5) == 0);
      scan_row       = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) blink_en = ~blink_en;
      step();
    end
    idle_inputs();
    blink_en = 0;

    // Reset while a swap is pending drops it; no acknowledge follows.
    swap_req = 1;
    step();
    swap_req = 0;
    check("pending_before_rst", {7'b0, busy}, 8'h01);
    rst = 1;
    step();
    rst = 0;
    ack_seen = 0;
    for (int r = 0; r < 8; r++) begin
      scan_row = 3'(r);
      scan_frame_end = 1;
      step();
      check("post_rst_row", row_data, 8'h00);
    end
    scan_frame_end = 0;
    check("post_rst_no_ack", 8'(ack_seen), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
